// File: rtl/mem_port_arbiter_pkg.sv
// Purpose: shared codes, state encoding and transaction record for the memory-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

    localparam int EXC_CODE_WIDTH = 5;

    // Exception codes seen on the MMU port.
    localparam logic [EXC_CODE_WIDTH-1:0] EC_NONE        = 5'h00;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_TLBL        = 5'h02;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_BUS_TIMEOUT = 5'h1f;

    localparam int DEF_STARVE_LIMIT = 4;
    localparam int DEF_TIMEOUT      = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    // One in-flight MMU transaction, held stable from issue until done.
    typedef struct packed {
        logic        is_inst;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_txn_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Purpose: combinational winner select between fetch and data, plus next value of the starvation streak.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller only uses the result while the arbiter is idle.
// Ports: if_req/d_req requests, streak_q current streak -> grant_vld, grant_inst (1 = fetch wins), streak_d.
module mem_arb_pick #(
    parameter int STARVE_LIMIT = 4,
    parameter int SW           = $clog2(STARVE_LIMIT + 1)
) (
    input  logic          if_req,
    input  logic          d_req,
    input  logic [SW-1:0] streak_q,
    output logic          grant_vld,
    output logic          grant_inst,
    output logic [SW-1:0] streak_d
);

    logic starved;

    always_comb begin
        // Fetch only beats data once data has won STARVE_LIMIT times in a row over a pending fetch.
        starved    = (streak_q == SW'(STARVE_LIMIT)) && if_req;
        grant_vld  = if_req || d_req;
        grant_inst = if_req && (!d_req || starved);

        streak_d = streak_q;
        if (!if_req || grant_inst) begin
            streak_d = '0;
        end else if (streak_q != SW'(STARVE_LIMIT)) begin
            streak_d = streak_q + SW'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares the single MMU port between instruction fetch and data access, one transaction at a time.
// Latency: request seen in IDLE -> ack pulse 3 cycles later, +1 per mem_busy cycle (abort after TIMEOUT busy cycles).
// Backpressure: requesters hold req until their ack; the losing requester simply stays pending.
// Ports: clk/rst; if_req/if_addr -> if_ack/if_rdata/if_exc; d_req/d_we/d_sel/d_addr/d_wdata -> d_ack/d_rdata/d_exc;
//        mem_req/mem_is_inst/mem_we/mem_sel/mem_addr/mem_wdata to the MMU, mem_rdata/mem_busy/mem_exc back.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int               STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int               TIMEOUT      = DEF_TIMEOUT,
    parameter int               EXC_W        = EXC_CODE_WIDTH,
    parameter logic [EXC_W-1:0] EXC_TIMEOUT  = EC_BUS_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [31:0]      if_addr,
    output logic             if_ack,
    output logic [31:0]      if_rdata,
    output logic [EXC_W-1:0] if_exc,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [3:0]       d_sel,
    input  logic [31:0]      d_addr,
    input  logic [31:0]      d_wdata,
    output logic             d_ack,
    output logic [31:0]      d_rdata,
    output logic [EXC_W-1:0] d_exc,
    output logic             mem_req,
    output logic             mem_is_inst,
    output logic             mem_we,
    output logic [3:0]       mem_sel,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_busy,
    input  logic [EXC_W-1:0] mem_exc
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_t       state_q, state_d;
    logic [SW-1:0]    streak_q, streak_d;
    logic [TW-1:0]    timer_q, timer_d;
    mem_txn_t         txn_q, txn_d;
    logic             mem_req_q, mem_req_d;
    logic             if_ack_q, if_ack_d;
    logic [31:0]      if_rdata_q, if_rdata_d;
    logic [EXC_W-1:0] if_exc_q, if_exc_d;
    logic             d_ack_q, d_ack_d;
    logic [31:0]      d_rdata_q, d_rdata_d;
    logic [EXC_W-1:0] d_exc_q, d_exc_d;

    logic             grant_vld, grant_inst;
    logic [SW-1:0]    pick_streak_d;
    logic             fin;
    logic [31:0]      fin_rdata;
    logic [EXC_W-1:0] fin_exc;

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .SW           (SW)
    ) u_pick (
        .if_req     (if_req),
        .d_req      (d_req),
        .streak_q   (streak_q),
        .grant_vld  (grant_vld),
        .grant_inst (grant_inst),
        .streak_d   (pick_streak_d)
    );

    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        timer_d    = timer_q;
        txn_d      = txn_q;
        mem_req_d  = 1'b0;
        if_ack_d   = 1'b0;
        if_rdata_d = if_rdata_q;
        if_exc_d   = if_exc_q;
        d_ack_d    = 1'b0;
        d_rdata_d  = d_rdata_q;
        d_exc_d    = d_exc_q;
        fin        = 1'b0;
        fin_rdata  = mem_rdata;
        fin_exc    = mem_exc;

        case (state_q)
            ST_IDLE: begin
                timer_d  = '0;
                streak_d = pick_streak_d;
                if (grant_vld) begin
                    if (grant_inst) begin
                        txn_d = '{is_inst: 1'b1, we: 1'b0, sel: 4'hf, addr: if_addr, wdata: 32'h0};
                    end else begin
                        txn_d = '{is_inst: 1'b0, we: d_we, sel: d_sel, addr: d_addr, wdata: d_wdata};
                    end
                    mem_req_d = 1'b1;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // The timeout check wins so a port stuck busy is abandoned after exactly TIMEOUT busy cycles.
                if (timer_q == TW'(TIMEOUT)) begin
                    fin       = 1'b1;
                    fin_rdata = 32'h0;
                    fin_exc   = EXC_TIMEOUT;
                end else if (!mem_busy) begin
                    fin = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Results land in the owning port's registers together with its ack and stay until its next ack.
        if (fin) begin
            state_d = ST_DONE;
            if (txn_q.is_inst) begin
                if_ack_d   = 1'b1;
                if_rdata_d = fin_rdata;
                if_exc_d   = fin_exc;
            end else begin
                d_ack_d   = 1'b1;
                d_rdata_d = fin_rdata;
                d_exc_d   = fin_exc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            streak_q   <= '0;
            timer_q    <= '0;
            txn_q      <= '0;
            mem_req_q  <= 1'b0;
            if_ack_q   <= 1'b0;
            if_rdata_q <= 32'h0;
            if_exc_q   <= '0;
            d_ack_q    <= 1'b0;
            d_rdata_q  <= 32'h0;
            d_exc_q    <= '0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            timer_q    <= timer_d;
            txn_q      <= txn_d;
            mem_req_q  <= mem_req_d;
            if_ack_q   <= if_ack_d;
            if_rdata_q <= if_rdata_d;
            if_exc_q   <= if_exc_d;
            d_ack_q    <= d_ack_d;
            d_rdata_q  <= d_rdata_d;
            d_exc_q    <= d_exc_d;
        end
    end

    assign if_ack      = if_ack_q;
    assign if_rdata    = if_rdata_q;
    assign if_exc      = if_exc_q;
    assign d_ack       = d_ack_q;
    assign d_rdata     = d_rdata_q;
    assign d_exc       = d_exc_q;
    assign mem_req     = mem_req_q;
    assign mem_is_inst = txn_q.is_inst;
    assign mem_we      = txn_q.we;
    assign mem_sel     = txn_q.sel;
    assign mem_addr    = txn_q.addr;
    assign mem_wdata   = txn_q.wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: scoreboard bench for mem_port_arbiter; directed stimulus queues expected acks, a monitor checks them.
// Latency: checks ack timing in cycles from the arbitration edge.
// Backpressure: requests are held until ack, as the requesters do.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam logic [31:0] K = 32'hA5A5_F00F;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic [4:0]  if_exc;
    logic        d_req, d_we;
    logic [3:0]  d_sel;
    logic [31:0] d_addr, d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic [4:0]  d_exc;
    logic        mem_req, mem_is_inst, mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_busy;
    logic [4:0]  mem_exc;

    // Memory model: read data is a fixed scramble of the issued address.
    assign mem_rdata = mem_addr ^ K;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_exc(if_exc),
        .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_exc(d_exc),
        .mem_req(mem_req), .mem_is_inst(mem_is_inst), .mem_we(mem_we), .mem_sel(mem_sel),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_busy(mem_busy), .mem_exc(mem_exc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        inst;
        logic [31:0] rdata;
        logic [4:0]  exc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   mem_req_cnt = 0;
    int   ack_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic expect_ack(input logic inst, input logic [31:0] rd, input logic [4:0] ex);
        exp_t e;
        e.inst  = inst;
        e.rdata = rd;
        e.exc   = ex;
        exp_q.push_back(e);
    endtask

    task automatic mon_check(input logic inst, input logic [31:0] rd, input logic [4:0] ex);
        exp_t e;
        tests++;
        ack_cnt++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL ack_unexpected: got port_inst=%0d rdata=%h exc=%h, required no ack", inst, rd, ex);
        end else begin
            e = exp_q.pop_front();
            if (inst !== e.inst || rd !== e.rdata || ex !== e.exc) begin
                fails++;
                $display("FAIL ack_data: got inst=%0d rdata=%h exc=%h, required inst=%0d rdata=%h exc=%h",
                         inst, rd, ex, e.inst, e.rdata, e.exc);
            end
        end
    endtask

    // Monitor: samples on the falling edge, away from the DUT's update edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req) mem_req_cnt++;
            if (if_ack) mon_check(1'b1, if_rdata, if_exc);
            if (d_ack)  mon_check(1'b0, d_rdata, d_exc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts ticks until the chosen port acks; a missing ack reports 0 ticks.
    task automatic wait_ack(input logic inst, input int limit, input int exp_n, input string name);
        int  n    = 0;
        bit  seen = 1'b0;
        while (!seen && n < limit) begin
            tick();
            n++;
            seen = inst ? if_ack : d_ack;
        end
        check(name, seen ? 64'(n) : 64'd0, 64'(exp_n));
    endtask

    task automatic settle();
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt0;
        int ack0;

        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_sel = '0;
        d_addr = '0; d_wdata = '0; mem_busy = 1'b0; mem_exc = EC_NONE;
        tick();
        tick();
        check("rst_ctrl", {60'd0, if_ack, d_ack, mem_req, mem_is_inst}, 64'd0);
        check("rst_rdata", {if_rdata, d_rdata}, 64'd0);
        check("rst_mem_bus", {mem_addr, mem_wdata}, 64'd0);
        check("rst_fields", {54'd0, if_exc, d_exc}, 64'd0);
        rst = 1'b0;
        tick();

        // Lone fetch.
        if_req = 1'b1; if_addr = 32'h8000_0000;
        expect_ack(1'b1, 32'h8000_0000 ^ K, EC_NONE);
        tick();
        check("t1_issue", {62'd0, mem_req, mem_is_inst}, 64'd3);
        check("t1_addr", 64'(mem_addr), 64'h8000_0000);
        tick();
        check("t1_req_once", 64'(mem_req), 64'd0);
        wait_ack(1'b1, 10, 1, "t1_ack_cycle3");
        if_req = 1'b0;
        settle();
        check("t1_rdata_hold", 64'(if_rdata), 64'(32'h8000_0000 ^ K));

        // Simultaneous fetch and store: store first, fetch ack 4 cycles after.
        if_req = 1'b1; if_addr = 32'h0000_1000;
        d_req = 1'b1; d_we = 1'b1; d_sel = 4'b1111; d_addr = 32'h0000_2000; d_wdata = 32'hDEAD_BEEF;
        expect_ack(1'b0, 32'h0000_2000 ^ K, EC_NONE);
        expect_ack(1'b1, 32'h0000_1000 ^ K, EC_NONE);
        tick();
        check("t2_issue_data", {62'd0, mem_req, mem_is_inst}, 64'd2);
        check("t2_store_fields", {27'd0, mem_we, mem_sel, mem_wdata}, {27'd0, 1'b1, 4'hf, 32'hDEAD_BEEF});
        tick();
        check("t2_wdata_stable", 64'(mem_wdata), 64'hDEAD_BEEF);
        wait_ack(1'b0, 10, 1, "t2_d_ack");
        d_req = 1'b0; d_we = 1'b0;
        wait_ack(1'b1, 10, 4, "t2_if_after_d");
        if_req = 1'b0;
        settle();

        // Starvation: two rounds of four data grants then one fetch grant.
        if_req = 1'b1; if_addr = 32'h0000_3000;
        d_req = 1'b1; d_we = 1'b0; d_sel = 4'b0011; d_addr = 32'h0000_4000;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) expect_ack(1'b0, 32'h0000_4000 ^ K, EC_NONE);
            expect_ack(1'b1, 32'h0000_3000 ^ K, EC_NONE);
        end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                wait_ack(1'b0, 10, (r == 0 && i == 0) ? 3 : 4, "t3_d_grant");
            end
            wait_ack(1'b1, 10, 4, "t3_if_forced");
        end
        if_req = 1'b0; d_req = 1'b0;
        settle();

        // Exception forwarded, not retried.
        mem_exc = EC_TLBL;
        cnt0 = mem_req_cnt;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_5000;
        expect_ack(1'b0, 32'h0000_5000 ^ K, EC_TLBL);
        wait_ack(1'b0, 10, 3, "t4_exc_ack");
        d_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("t4_single_issue", 64'(mem_req_cnt - cnt0), 64'd1);
        mem_exc = EC_NONE;

        // Busy stuck high: timeout after 255 busy cycles, then a normal fetch.
        mem_busy = 1'b1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_6000; d_wdata = 32'h1234_5678;
        expect_ack(1'b0, 32'h0, EC_BUS_TIMEOUT);
        wait_ack(1'b0, 400, 258, "t5_timeout_ack");
        d_req = 1'b0; d_we = 1'b0;
        for (int i = 0; i < 42; i++) tick();
        mem_busy = 1'b0;
        settle();
        if_req = 1'b1; if_addr = 32'h0000_7000;
        expect_ack(1'b1, 32'h0000_7000 ^ K, EC_NONE);
        wait_ack(1'b1, 10, 3, "t5_after_timeout");
        if_req = 1'b0;
        settle();

        // Reset while waiting on a busy MMU.
        mem_busy = 1'b1;
        d_req = 1'b1; d_addr = 32'h0000_8000;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("t6_rst_quiet", {61'd0, mem_req, d_ack, if_ack}, 64'd0);
        rst = 1'b0; d_req = 1'b0; mem_busy = 1'b0;
        ack0 = ack_cnt;
        for (int i = 0; i < 6; i++) tick();
        check("t6_no_ack", 64'(ack_cnt - ack0), 64'd0);
        d_req = 1'b1; d_addr = 32'h0000_9000;
        expect_ack(1'b0, 32'h0000_9000 ^ K, EC_NONE);
        wait_ack(1'b0, 10, 3, "t6_fresh_req");
        d_req = 1'b0;
        settle();

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
